// File: rtl/isla_tx_pkg.sv
// ---------------------------------------------------------------------------
// isla_tx_pkg
// Shared constants and types for the ISLA transmit pattern generator:
// lane/sample geometry, pattern mode encodings, FSM states, and the PRBS15
// polynomial taps with a one-step helper.
// ---------------------------------------------------------------------------
package isla_tx_pkg;

  localparam int unsigned ISLA_LANES    = 8;
  localparam int unsigned ISLA_SAMPLE_W = 16;

  // Pattern modes; encodings 5..7 are reserved and emit zero.
  typedef enum logic [2:0] {
    MODE_FIXED  = 3'd0,
    MODE_RAMP   = 3'd1,
    MODE_TOGGLE = 3'd2,
    MODE_PRBS15 = 3'd3,
    MODE_WALK   = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_DONE
  } state_e;

  // x^15 + x^14 + 1, Fibonacci form, shifting toward the MSB.
  localparam int unsigned PRBS_W     = 15;
  localparam int unsigned PRBS_TAP_A = 14;
  localparam int unsigned PRBS_TAP_B = 13;

  function automatic logic [PRBS_W-1:0] prbs15_next(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/isla_tx_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// isla_tx_pattern_gen_if
// Control and lane-output bundle of the ISLA transmit pattern generator.
//   master: drives enable/mode/fixed_pattern/burst_len/trigger/lane_inv,
//           observes d_rise/d_fall/sample/sample_valid/frame/busy/done.
//   slave : the generator side (inputs and outputs reversed).
// ---------------------------------------------------------------------------
interface isla_tx_pattern_gen_if #(
  parameter int unsigned LEN_W = 16
);
  logic                                    enable;
  logic [2:0]                              mode;
  logic [isla_tx_pkg::ISLA_SAMPLE_W-1:0]   fixed_pattern;
  logic [LEN_W-1:0]                        burst_len;
  logic                                    trigger;
  logic [isla_tx_pkg::ISLA_LANES-1:0]      lane_inv;
  logic [isla_tx_pkg::ISLA_LANES-1:0]      d_rise;
  logic [isla_tx_pkg::ISLA_LANES-1:0]      d_fall;
  logic [isla_tx_pkg::ISLA_SAMPLE_W-1:0]   sample;
  logic                                    sample_valid;
  logic                                    frame;
  logic                                    busy;
  logic                                    done;

  modport master (
    output enable, mode, fixed_pattern, burst_len, trigger, lane_inv,
    input  d_rise, d_fall, sample, sample_valid, frame, busy, done
  );

  modport slave (
    input  enable, mode, fixed_pattern, burst_len, trigger, lane_inv,
    output d_rise, d_fall, sample, sample_valid, frame, busy, done
  );
endinterface

// File: rtl/isla_tx_lane_map.sv
// ---------------------------------------------------------------------------
// isla_tx_lane_map
// Combinational sample -> DDR lane mapping, matching the ISLA receiver:
//   lane i rising  half = sample[2i]   ^ lane_inv[i]
//   lane i falling half = sample[2i+1] ^ lane_inv[i]
// Ports: i_sample (16), i_lane_inv (8) -> o_d_rise (8), o_d_fall (8).
// ---------------------------------------------------------------------------
module isla_tx_lane_map
  import isla_tx_pkg::*;
(
  input  logic [ISLA_SAMPLE_W-1:0] i_sample,
  input  logic [ISLA_LANES-1:0]    i_lane_inv,
  output logic [ISLA_LANES-1:0]    o_d_rise,
  output logic [ISLA_LANES-1:0]    o_d_fall
);

  always_comb begin
    o_d_rise = '0;
    o_d_fall = '0;
    for (int unsigned i = 0; i < ISLA_LANES; i++) begin
      o_d_rise[i] = i_sample[2*i]   ^ i_lane_inv[i];
      o_d_fall[i] = i_sample[2*i+1] ^ i_lane_inv[i];
    end
  end

endmodule

// File: rtl/isla_tx_pattern_gen.sv
// ---------------------------------------------------------------------------
// isla_tx_pattern_gen
// Synthesises 16-bit test samples (fixed, ramp, toggle, PRBS15, walking-one)
// and serialises each onto 8 DDR lanes for the ISLA receive path.
// Ports:
//   sys_clk - sample clock, one sample per cycle
//   rst_n   - asynchronous active-low reset
//   bus     - isla_tx_pattern_gen_if.slave: enable, mode, fixed_pattern,
//             burst_len (0 = continuous), trigger (rising edge starts a burst),
//             lane_inv; registered d_rise, d_fall, sample, sample_valid,
//             frame, busy, done.
// ---------------------------------------------------------------------------
module isla_tx_pattern_gen
  import isla_tx_pkg::*;
#(
  parameter logic [PRBS_W-1:0] PRBS_SEED = 15'h7FFF,
  parameter int unsigned       LEN_W     = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  isla_tx_pattern_gen_if.slave  bus
);

  // An all-zero LFSR would lock up, so a zero seed is coerced to 1.
  localparam logic [PRBS_W-1:0] SEED    = (PRBS_SEED == '0) ? 15'h0001 : PRBS_SEED;
  localparam logic [LEN_W-1:0]  LEN_ONE = 1;

  state_e                   r_state;
  logic                     r_trig_q;
  logic [2:0]               r_mode;
  logic [ISLA_SAMPLE_W-1:0] r_fixed;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         r_cnt;
  logic [ISLA_SAMPLE_W-1:0] r_ramp;
  logic [PRBS_W-1:0]        r_lfsr;
  logic [ISLA_SAMPLE_W-1:0] r_walk;
  logic                     r_tog;

  logic [ISLA_SAMPLE_W-1:0] r_sample;
  logic [ISLA_LANES-1:0]    r_d_rise;
  logic [ISLA_LANES-1:0]    r_d_fall;
  logic                     r_valid;
  logic                     r_frame;
  logic                     r_busy;
  logic                     r_done;

  logic                     w_trig_edge;
  logic                     w_emit;
  logic                     w_last;
  logic [ISLA_SAMPLE_W-1:0] w_gen;
  logic [ISLA_SAMPLE_W-1:0] w_next_sample;
  logic [ISLA_LANES-1:0]    w_d_rise;
  logic [ISLA_LANES-1:0]    w_d_fall;

  assign w_trig_edge   = bus.trigger & ~r_trig_q;
  // A sample is emitted on every RUN cycle that is not being aborted.
  assign w_emit        = (r_state == ST_RUN) && bus.enable;
  assign w_last        = (r_len != '0) && (r_cnt == r_len - LEN_ONE);
  assign w_next_sample = w_emit ? w_gen : '0;

  always_comb begin
    w_gen = '0;
    case (r_mode)
      MODE_FIXED:  w_gen = r_fixed;
      MODE_RAMP:   w_gen = r_ramp;
      MODE_TOGGLE: w_gen = r_tog ? ~r_fixed : r_fixed;
      MODE_PRBS15: w_gen = {r_lfsr[PRBS_W-1], r_lfsr};
      MODE_WALK:   w_gen = r_walk;
      default:     w_gen = '0;
    endcase
  end

  // Idle cycles map a zero sample, so the lanes rest at lane_inv.
  isla_tx_lane_map u_lane_map (
    .i_sample   (w_next_sample),
    .i_lane_inv (bus.lane_inv),
    .o_d_rise   (w_d_rise),
    .o_d_fall   (w_d_fall)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_trig_q <= 1'b0;
      r_mode   <= '0;
      r_fixed  <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_ramp   <= '0;
      r_lfsr   <= SEED;
      r_walk   <= 16'h0001;
      r_tog    <= 1'b0;
      r_sample <= '0;
      r_d_rise <= '0;
      r_d_fall <= '0;
      r_valid  <= 1'b0;
      r_frame  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_trig_q <= bus.trigger;
      r_sample <= w_next_sample;
      r_d_rise <= w_d_rise;
      r_d_fall <= w_d_fall;
      r_valid  <= w_emit;
      // busy is registered alongside each emitted sample, so it frames
      // exactly the cycles the lanes carry burst data.
      r_busy   <= w_emit;
      // The counter saturates in continuous mode, so it never returns to 0
      // and frame cannot re-fire.
      r_frame  <= w_emit && (r_cnt == '0);
      r_done   <= 1'b0;

      if (!bus.enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_ARMED;
          ST_ARMED: begin
            if (w_trig_edge) begin
              r_mode  <= bus.mode;
              r_fixed <= bus.fixed_pattern;
              r_len   <= bus.burst_len;
              r_cnt   <= '0;
              r_ramp  <= '0;
              r_lfsr  <= SEED;
              r_walk  <= 16'h0001;
              r_tog   <= 1'b0;
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            r_ramp <= r_ramp + 16'd1;
            r_lfsr <= prbs15_next(r_lfsr);
            r_walk <= {r_walk[ISLA_SAMPLE_W-2:0], r_walk[ISLA_SAMPLE_W-1]};
            r_tog  <= ~r_tog;
            if (r_cnt != '1) r_cnt <= r_cnt + LEN_ONE;
            if (w_last) r_state <= ST_DONE;
          end
          ST_DONE: begin
            r_done  <= 1'b1;
            r_state <= ST_ARMED;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sample       = r_sample;
  assign bus.d_rise       = r_d_rise;
  assign bus.d_fall       = r_d_fall;
  assign bus.sample_valid = r_valid;
  assign bus.frame        = r_frame;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_isla_tx_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_isla_tx_pattern_gen
// Self-checking bench: expected samples are derived from the pattern rules
// (index-based ramp/toggle/walk, a precomputed PRBS15 table) and the lane
// rule, then compared cycle by cycle with the registered outputs.
// ---------------------------------------------------------------------------
module tb_isla_tx_pattern_gen;

  localparam int unsigned PRBS_PERIOD = 32767;

  logic sys_clk = 1'b0;
  logic rst_n;

  always #5 sys_clk = ~sys_clk;

  isla_tx_pattern_gen_if #(.LEN_W(16)) bus ();

  isla_tx_pattern_gen #(
    .PRBS_SEED (15'h7FFF),
    .LEN_W     (16)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] prbs_tab [0:PRBS_PERIOD-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected k-th sample of a burst (k counts from 0).
  function automatic logic [15:0] ref_sample(input int unsigned mode, input logic [15:0] fp,
                                             input int unsigned k);
    logic [15:0] one;
    one = 16'h0001;
    case (mode)
      0:       return fp;
      1:       return 16'(k % 65536);
      2:       return (k % 2 == 1) ? ~fp : fp;
      3:       return prbs_tab[k % PRBS_PERIOD];
      4:       return one << (k % 16);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] ref_lane(input logic [15:0] s, input logic [7:0] inv,
                                          input int unsigned half);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = s[2*i + half] ^ inv[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] es, input logic ev,
                           input logic ef, input logic eb, input logic ed);
    chk({tag, ".sample"}, 32'(bus.sample), 32'(es));
    chk({tag, ".valid"},  32'(bus.sample_valid), 32'(ev));
    chk({tag, ".frame"},  32'(bus.frame), 32'(ef));
    chk({tag, ".busy"},   32'(bus.busy), 32'(eb));
    chk({tag, ".done"},   32'(bus.done), 32'(ed));
    chk({tag, ".rise"},   32'(bus.d_rise), 32'(ref_lane(es, bus.lane_inv, 0)));
    chk({tag, ".fall"},   32'(bus.d_fall), 32'(ref_lane(es, bus.lane_inv, 1)));
  endtask

  // Starts a burst from ARMED and checks it through the done pulse.
  // noise=1 scrambles lane_inv every cycle and pokes the (latched) control
  // inputs and trigger during the burst, all of which must be ignored.
  task automatic run_burst(input string tag, input int unsigned mode, input logic [15:0] fp,
                           input int unsigned len, input bit noise);
    bus.mode          = 3'(mode);
    bus.fixed_pattern = fp;
    bus.burst_len     = 16'(len);
    bus.trigger       = 1'b1;
    tick();
    check_out({tag, ".arm"}, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < len; k++) begin
      if (noise) begin
        bus.lane_inv      = 8'($urandom);
        bus.mode          = 3'($urandom);
        bus.fixed_pattern = 16'($urandom);
        bus.burst_len     = 16'($urandom);
        bus.trigger       = 1'($urandom);
      end
      tick();
      check_out($sformatf("%s.s%0d", tag, k), ref_sample(mode, fp, k), 1'b1, k == 0, 1'b1, 1'b0);
    end
    bus.trigger = 1'b0;
    if (noise) bus.lane_inv = 8'($urandom);
    tick();
    check_out({tag, ".done"}, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_out({tag, ".post"}, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [14:0] s;
    s = 15'h7FFF;
    for (int i = 0; i < int'(PRBS_PERIOD); i++) begin
      prbs_tab[i] = {s[14], s};
      s = {s[13:0], s[14] ^ s[13]};
    end

    rst_n             = 1'b0;
    bus.enable        = 1'b0;
    bus.mode          = '0;
    bus.fixed_pattern = '0;
    bus.burst_len     = '0;
    bus.trigger       = 1'b0;
    bus.lane_inv      = 8'h5A;
    #12;
    chk("rst.sample", 32'(bus.sample), 32'h0);
    chk("rst.rise",   32'(bus.d_rise), 32'h0);
    chk("rst.fall",   32'(bus.d_fall), 32'h0);
    chk("rst.valid",  32'(bus.sample_valid), 32'h0);
    chk("rst.done",   32'(bus.done), 32'h0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    tick();
    check_out("idle", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    bus.enable = 1'b1;
    tick();

    // Ramp burst, then lane mapping with and without inversion.
    bus.lane_inv = 8'h00;
    run_burst("ramp5", 1, 16'h0, 5, 1'b0);
    bus.lane_inv = 8'h81;
    run_burst("map81", 0, 16'hA5C3, 2, 1'b0);
    bus.lane_inv = 8'h00;
    run_burst("map00", 0, 16'hA5C3, 2, 1'b0);

    // Walking-one through a full rotation and back to 0001; toggle.
    run_burst("walk17", 4, 16'h0, 17, 1'b0);
    run_burst("tog", 2, 16'h1234, 4, 1'b1);

    // Randomised bursts over all modes, including reserved ones.
    for (int n = 0; n < 24; n++)
      run_burst($sformatf("rnd%0d", n), $urandom_range(0, 7), 16'($urandom),
                $urandom_range(1, 40), 1'b1);

    // Continuous PRBS15 across more than one full period.
    bus.mode      = 3'd3;
    bus.burst_len = 16'd0;
    bus.trigger   = 1'b1;
    tick();
    bus.trigger = 1'b0;
    for (int unsigned k = 0; k < PRBS_PERIOD + 8; k++) begin
      tick();
      chk($sformatf("prbs.s%0d", k), 32'(bus.sample), 32'(prbs_tab[k % PRBS_PERIOD]));
      if (k < 3 || k > PRBS_PERIOD) begin
        chk("prbs.frame", 32'(bus.frame), 32'(k == 0));
        chk("prbs.busy",  32'(bus.busy), 32'h1);
      end
    end
    bus.enable = 1'b0;
    tick();
    check_out("prbs.stop", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("prbs.stop2", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort at sample 3 of a 10-sample burst.
    bus.enable = 1'b1;
    tick();
    bus.mode      = 3'd1;
    bus.burst_len = 16'd10;
    bus.trigger   = 1'b1;
    tick();
    bus.trigger = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      check_out($sformatf("abort.s%0d", k), 16'(k), 1'b1, k == 0, 1'b1, 1'b0);
    end
    bus.enable = 1'b0;
    tick();
    check_out("abort.drop", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("abort.nodone", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Trigger rising with enable, then held high: no burst may start.
    bus.enable  = 1'b1;
    bus.trigger = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      check_out($sformatf("hold%0d", k), 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.trigger = 1'b0;
    tick();
    run_burst("rearm", 1, 16'h0, 3, 1'b0);

    // Asynchronous reset in the middle of a burst.
    bus.lane_inv  = 8'hFF;
    bus.mode      = 3'd3;
    bus.burst_len = 16'd10;
    bus.trigger   = 1'b1;
    tick();
    bus.trigger = 1'b0;
    tick();
    tick();
    chk("prerst.valid", 32'(bus.sample_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.sample", 32'(bus.sample), 32'h0);
    chk("arst.rise",   32'(bus.d_rise), 32'h0);
    chk("arst.fall",   32'(bus.d_fall), 32'h0);
    chk("arst.valid",  32'(bus.sample_valid), 32'h0);
    chk("arst.frame",  32'(bus.frame), 32'h0);
    chk("arst.busy",   32'(bus.busy), 32'h0);
    chk("arst.done",   32'(bus.done), 32'h0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    tick();
    check_out("postrst", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("postrst2", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_burst("reseed", 3, 16'h0, 5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
